// File: rtl/conv_mac_pkg.sv
// Shared types and default sizes for the convolution MAC controller.
// Imported by the interface and the controller.
package conv_mac_pkg;

    localparam int unsigned LEN_DEF     = 32;
    localparam int unsigned ACC_LEN_DEF = 72;
    localparam int unsigned CNT_LEN_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_e;

endpackage

// File: rtl/conv_mac_ctrl_if.sv
// Operand stream, multiplier link and result stream of the MAC controller.
// slave is the controller side; master is the surrounding datapath.
interface conv_mac_ctrl_if
    import conv_mac_pkg::*;
#(
    parameter int unsigned LEN     = LEN_DEF,
    parameter int unsigned ACC_LEN = ACC_LEN_DEF,
    parameter int unsigned CNT_LEN = CNT_LEN_DEF
) ();

    logic               in_valid;
    logic               in_ready;
    logic [LEN-1:0]     in_a;
    logic [LEN-1:0]     in_b;
    logic               in_last;

    logic               mul_start;
    logic [LEN-1:0]     mul_multiplicand;
    logic [LEN-1:0]     mul_multiplier;
    logic [2*LEN-1:0]   mul_product;
    logic               mul_finish;

    logic               out_valid;
    logic               out_ready;
    logic [ACC_LEN-1:0] out_sum;
    logic [CNT_LEN-1:0] out_count;
    logic               out_overflow;

    modport slave (
        input  in_valid, in_a, in_b, in_last,
        output in_ready,
        output mul_start, mul_multiplicand, mul_multiplier,
        input  mul_product, mul_finish,
        output out_valid, out_sum, out_count, out_overflow,
        input  out_ready
    );

    modport master (
        output in_valid, in_a, in_b, in_last,
        input  in_ready,
        input  mul_start, mul_multiplicand, mul_multiplier,
        output mul_product, mul_finish,
        input  out_valid, out_sum, out_count, out_overflow,
        output out_ready
    );

endinterface

// File: rtl/conv_mac_ctrl.sv
// Dot-product controller: one external multiply per operand pair,
// accumulated into a wide sum and released on the pair tagged last.
module conv_mac_ctrl
    import conv_mac_pkg::*;
#(
    parameter int unsigned LEN     = LEN_DEF,
    parameter int unsigned ACC_LEN = ACC_LEN_DEF,
    parameter int unsigned CNT_LEN = CNT_LEN_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    conv_mac_ctrl_if.slave bus
);

    localparam int unsigned PAD = ACC_LEN + 1 - 2 * LEN;

    state_e             state_q;
    logic [LEN-1:0]     a_q;
    logic [LEN-1:0]     b_q;
    logic               last_q;
    logic [ACC_LEN-1:0] acc_q;
    logic [CNT_LEN-1:0] cnt_q;
    logic               ovf_q;
    logic               start_q;
    logic               valid_q;
    logic               ready_q;

    // Extra top bit captures the carry out of the accumulator.
    logic [ACC_LEN:0]   sum_d;
    logic [CNT_LEN-1:0] cnt_d;

    assign sum_d = {1'b0, acc_q}
                 + {{PAD{1'b0}}, bus.mul_product};
    assign cnt_d = cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            last_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.in_a;
                        b_q     <= bus.in_b;
                        last_q  <= bus.in_last;
                        ready_q <= 1'b0;
                        start_q <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    start_q <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (bus.mul_finish) begin
                        acc_q <= sum_d[ACC_LEN-1:0];
                        ovf_q <= ovf_q | sum_d[ACC_LEN];
                        cnt_q <= cnt_d;
                        if (last_q) begin
                            valid_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready         = ready_q;
    assign bus.mul_start        = start_q;
    assign bus.mul_multiplicand = a_q;
    assign bus.mul_multiplier   = b_q;
    assign bus.out_valid        = valid_q;
    assign bus.out_sum          = acc_q;
    assign bus.out_count        = cnt_q;
    assign bus.out_overflow     = ovf_q;

endmodule

// File: tb/tb_conv_mac_ctrl.sv
// Directed bench for conv_mac_ctrl with a behavioural shift-add multiplier.
// Accumulator is 64 bits so the wrap case is reachable.
module tb_conv_mac_ctrl;

    localparam int unsigned LEN  = 32;
    localparam int unsigned ACCL = 64;
    localparam int unsigned CNTL = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   starts = 0;

    conv_mac_ctrl_if #(.LEN(LEN), .ACC_LEN(ACCL), .CNT_LEN(CNTL)) bus ();

    conv_mac_ctrl #(.LEN(LEN), .ACC_LEN(ACCL), .CNT_LEN(CNTL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Multiplier model: start, LEN work cycles, then a one-cycle finish.
    logic [2*LEN-1:0] m_prod;
    logic             m_fin;
    int unsigned      m_cnt;
    logic             spur_fin;
    logic [2*LEN-1:0] spur_prod;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_fin  <= 1'b0;
            m_prod <= '0;
        end else begin
            m_fin <= 1'b0;
            if (m_cnt != 0) m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_fin  <= 1'b1;
                m_prod <= 64'(bus.mul_multiplicand)
                        * 64'(bus.mul_multiplier);
            end
            if (bus.mul_start) m_cnt <= LEN;
        end
    end

    assign bus.mul_finish  = m_fin | spur_fin;
    assign bus.mul_product = spur_fin ? spur_prod
                           : m_fin ? m_prod : 64'h0BAD_0BAD_0BAD_0BAD;

    always @(posedge clk)
        if (bus.mul_start === 1'b1) starts <= starts + 1;

    task automatic send_pair(input logic [31:0] a, input logic [31:0] b,
                             input logic last);
        int n = 0;
        @(negedge clk);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL send_ready: in_ready=%b want 1", bus.in_ready);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.out_valid !== 1'b1 && k < 200);
        tests++;
        if (bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL wait_valid: out_valid=%b want 1", bus.out_valid);
        end
    endtask

    task automatic take_result();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic check_result(input string nm,
                                input logic [63:0] s,
                                input logic [15:0] c,
                                input logic o);
        tests++;
        if (bus.out_sum !== s || bus.out_count !== c
            || bus.out_overflow !== o) begin
            fails++;
            $display("FAIL %s: sum=%h cnt=%0d ovf=%b want %h %0d %b",
                     nm, bus.out_sum, bus.out_count, bus.out_overflow,
                     s, c, o);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0
            || bus.mul_start !== 1'b0 || bus.out_sum !== 64'd0
            || bus.out_count !== 16'd0 || bus.out_overflow !== 1'b0
            || bus.mul_multiplicand !== 32'd0) begin
            fails++;
            $display("FAIL reset: rdy=%b vld=%b st=%b sum=%h cnt=%0d",
                     bus.in_ready, bus.out_valid, bus.mul_start,
                     bus.out_sum, bus.out_count);
        end
    endtask

    task automatic test_single();
        int st_k = -1;
        int vl_k = -1;
        int s0;
        s0 = starts;
        send_pair(32'd3, 32'd5, 1'b1);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (bus.mul_start === 1'b1 && st_k < 0) st_k = k;
            if (bus.out_valid === 1'b1 && vl_k < 0) vl_k = k;
            if (k == 10) begin
                tests++;
                if (bus.mul_multiplicand !== 32'd3
                    || bus.mul_multiplier !== 32'd5
                    || bus.in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL single_ops: a=%0d b=%0d rdy=%b",
                             bus.mul_multiplicand, bus.mul_multiplier,
                             bus.in_ready);
                end
            end
        end
        tests++;
        if (st_k != 1) begin
            fails++;
            $display("FAIL single_start_lat: got %0d want 1", st_k);
        end
        tests++;
        if (vl_k != 35) begin
            fails++;
            $display("FAIL single_valid_lat: got %0d want 35", vl_k);
        end
        tests++;
        if (starts - s0 != 1) begin
            fails++;
            $display("FAIL single_starts: got %0d want 1", starts - s0);
        end
        check_result("single", 64'd15, 16'd1, 1'b0);
        take_result();
        @(negedge clk);
        tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL single_release: vld=%b rdy=%b want 0 1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_multi();
        int s0;
        int k;
        logic [31:0] va [4] = '{32'd1, 32'd3, 32'd5, 32'd7};
        logic [31:0] vb [4] = '{32'd2, 32'd4, 32'd6, 32'd8};
        s0 = starts;
        for (int i = 0; i < 4; i++) begin
            send_pair(va[i], vb[i], i == 3);
            @(negedge clk);
            tests++;
            if (bus.in_ready !== 1'b0) begin
                fails++;
                $display("FAIL multi_busy%0d: in_ready=%b want 0",
                         i, bus.in_ready);
            end
        end
        wait_valid(k);
        tests++;
        if (starts - s0 != 4) begin
            fails++;
            $display("FAIL multi_starts: got %0d want 4", starts - s0);
        end
        check_result("multi", 64'd100, 16'd4, 1'b0);
        take_result();
    endtask

    task automatic test_overflow();
        int k;
        send_pair(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        send_pair(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_valid(k);
        check_result("ovf_wrap", 64'hFFFF_FFFC_0000_0002, 16'd2, 1'b1);
        take_result();
        send_pair(32'd1, 32'd1, 1'b1);
        wait_valid(k);
        check_result("ovf_clear", 64'd1, 16'd1, 1'b0);
        take_result();
    endtask

    task automatic test_backpressure();
        int k;
        int s0;
        send_pair(32'd3, 32'd4, 1'b1);
        wait_valid(k);
        s0 = starts;
        bus.in_valid = 1'b1;
        bus.in_a     = 32'd9;
        bus.in_b     = 32'd9;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0
                || bus.out_sum !== 64'd12 || bus.out_count !== 16'd1) begin
                fails++;
                $display("FAIL bp_hold%0d: vld=%b rdy=%b sum=%0d cnt=%0d",
                         i, bus.out_valid, bus.in_ready,
                         bus.out_sum, bus.out_count);
            end
        end
        bus.in_valid = 1'b0;
        tests++;
        if (starts != s0) begin
            fails++;
            $display("FAIL bp_starts: got %0d want %0d", starts, s0);
        end
        take_result();
        @(negedge clk);
        tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1
            || bus.out_sum !== 64'd0 || bus.out_count !== 16'd0) begin
            fails++;
            $display("FAIL bp_release: vld=%b rdy=%b sum=%0d cnt=%0d",
                     bus.out_valid, bus.in_ready, bus.out_sum,
                     bus.out_count);
        end
    endtask

    task automatic test_spurious();
        int k;
        @(negedge clk);
        spur_prod = 64'h1234;
        spur_fin  = 1'b1;
        @(negedge clk);
        spur_fin  = 1'b0;
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0
            || bus.out_sum !== 64'd0 || bus.out_count !== 16'd0
            || bus.mul_start !== 1'b0) begin
            fails++;
            $display("FAIL spur_idle: rdy=%b vld=%b sum=%h cnt=%0d",
                     bus.in_ready, bus.out_valid, bus.out_sum,
                     bus.out_count);
        end
        send_pair(32'd1, 32'd1, 1'b1);
        wait_valid(k);
        check_result("spur_next", 64'd1, 16'd1, 1'b0);
        take_result();
    endtask

    task automatic test_reset_mid();
        int k;
        send_pair(32'd5, 32'd5, 1'b0);
        repeat (10) @(negedge clk);
        tests++;
        if (bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL mid_wait: in_ready=%b want 0", bus.in_ready);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_sum !== 64'd0
            || bus.mul_multiplicand !== 32'd0) begin
            fails++;
            $display("FAIL mid_async: rdy=%b sum=%h a=%h",
                     bus.in_ready, bus.out_sum, bus.mul_multiplicand);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_pair(32'd2, 32'd2, 1'b1);
        wait_valid(k);
        check_result("mid_after", 64'd4, 16'd1, 1'b0);
        take_result();
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        spur_fin      = 1'b0;
        spur_prod     = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_single();
        test_multi();
        test_overflow();
        test_backpressure();
        test_spurious();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
